// File: rtl/mem_resp_pkg.sv
// =============================================================================
//  Module      : mem_resp_pkg
//  Description : Shared access-size encodings, FSM states and alignment helper
//                for the memory-stage responder.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mem_resp_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Undefined size codes behave as word accesses, so only [1:0] matters.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
        case (size[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_resp_lane.sv
// =============================================================================
//  Module      : mem_resp_lane
//  Description : Combinational byte-lane logic: store byte enables/data and
//                load extraction with sign/zero extension.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_resp_lane
    import mem_resp_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rbytes,
    output logic [3:0]  be,
    output logic [31:0] wbytes,
    output logic [31:0] rdata
);

    // Lane k always maps to byte address addr+k, so store data stays right-aligned.
    assign wbytes = wdata;

    always_comb begin
        be = 4'b1111;
        case (size[1:0])
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        rdata = rbytes;
        case (size)
            SZ_B:    rdata = {{24{rbytes[7]}}, rbytes[7:0]};
            SZ_H:    rdata = {{16{rbytes[15]}}, rbytes[15:0]};
            SZ_BU:   rdata = {24'd0, rbytes[7:0]};
            SZ_HU:   rdata = {16'd0, rbytes[15:0]};
            SZ_W:    rdata = rbytes;
            default: rdata = rbytes;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// =============================================================================
//  Module      : mem_responder
//  Description : Fixed-latency byte-addressed data memory behind a
//                request/ready handshake. Optional misalignment trap enabled
//                by defining MEM_RESP_ALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            SizeCtr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  MemReady,
    output logic                  MemErr
);

    localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);
    localparam bit         C_SINGLE   = (LATENCY == 1);

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [2:0]              r_size;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_is_write;
    logic [7:0]              r_mem [0:(1<<ADDR_WIDTH)-1];

    logic                    w_req;
    logic                    w_enter_resp;
    logic                    w_misaligned;
    logic                    w_acc_write;
    logic [ADDR_WIDTH-1:0]   w_acc_addr;
    logic [2:0]              w_acc_size;
    logic [ADDR_WIDTH-1:0]   w_byte_addr [4];
    logic [31:0]             w_rbytes;
    logic [31:0]             w_wbytes;
    logic [31:0]             w_load;
    logic [3:0]              w_be;
    logic                    w_mem_we;

    assign w_req = MemRead | MemWrite;

    // In IDLE the live inputs are used so a single-cycle latency can read at acceptance.
    assign w_acc_addr  = (r_state == IDLE) ? addr     : r_addr;
    assign w_acc_size  = (r_state == IDLE) ? SizeCtr  : r_size;
    assign w_acc_write = (r_state == IDLE) ? MemWrite : r_is_write;

    assign w_enter_resp = w_req && (((r_state == IDLE) && C_SINGLE) ||
                                    ((r_state == BUSY) && (r_cnt == 4'd1)));

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(w_acc_size, w_acc_addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    generate
        for (genvar k = 0; k < 4; k++) begin : g_byte
            assign w_byte_addr[k]    = w_acc_addr + ADDR_WIDTH'(k);
            assign w_rbytes[8*k +: 8] = r_mem[w_byte_addr[k]];
        end
    endgenerate

    mem_resp_lane u_lane (
        .size   (w_acc_size),
        .wdata  (r_wdata),
        .rbytes (w_rbytes),
        .be     (w_be),
        .wbytes (w_wbytes),
        .rdata  (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_size     <= 3'd0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            ReadData   <= '0;
            MemReady   <= 1'b0;
            MemErr     <= 1'b0;
        end else begin
            MemReady <= 1'b0;
            MemErr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr     <= addr;
                        r_size     <= SizeCtr;
                        r_wdata    <= WriteData;
                        r_is_write <= MemWrite;
                        r_cnt      <= C_CNT_INIT;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_enter_resp) begin
                r_state  <= RESP;
                MemReady <= 1'b1;
                MemErr   <= w_misaligned;
                if (!w_acc_write && !w_misaligned) begin
                    ReadData <= w_load;
                end
            end
        end
    end

    // MemErr is high only during RESP, so it doubles as the store-suppress flag.
    assign w_mem_we = !rst && (r_state == RESP) && r_is_write && !MemErr;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_byte_addr[k]] <= w_wbytes[8*k +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// =============================================================================
//  Module      : tb_mem_responder
//  Description : Randomized self-checking bench for mem_responder (LATENCY 3
//                and LATENCY 1 instances) against a byte-array reference model.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [2:0]  SizeCtr;
    logic [16:0] addr;
    logic [31:0] WriteData;
    logic        sel1;

    logic        w_rd3, w_wr3, w_rd1, w_wr1;
    logic [31:0] rdata3, rdata1;
    logic        rdy3, rdy1, err3, err1;
    logic        w_ready, w_err;
    logic [31:0] w_rdata;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  ref_mem [int];
    logic [31:0] ref_rd [2];

    always #5 clk = ~clk;

    assign w_rd3 = MemRead  & ~sel1;
    assign w_wr3 = MemWrite & ~sel1;
    assign w_rd1 = MemRead  &  sel1;
    assign w_wr1 = MemWrite &  sel1;

    assign w_ready = sel1 ? rdy1   : rdy3;
    assign w_err   = sel1 ? err1   : err3;
    assign w_rdata = sel1 ? rdata1 : rdata3;

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .MemRead(w_rd3), .MemWrite(w_wr3), .SizeCtr(SizeCtr),
        .addr(addr), .WriteData(WriteData), .ReadData(rdata3), .MemReady(rdy3), .MemErr(err3)
    );

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .MemRead(w_rd1), .MemWrite(w_wr1), .SizeCtr(SizeCtr),
        .addr(addr), .WriteData(WriteData), .ReadData(rdata1), .MemReady(rdy1), .MemErr(err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit ref_mis(input logic [2:0] sz, input logic [16:0] a);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        case (sz)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return (a % 2) != 0;
            default:        return (a % 4) != 0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    function automatic int key(input logic [16:0] a, input int k);
        return (int'(a) + k) % (1 << 17);
    endfunction

    // Reference: update model memory / expected load result for one completed access.
    task automatic ref_access(input logic rd, input logic wr, input logic [2:0] sz,
                              input logic [16:0] a, input logic [31:0] wd, input int d);
        int n;
        logic [31:0] v;
        if (ref_mis(sz, a)) return;
        if (wr) begin
            n = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
            for (int k = 0; k < n; k++) ref_mem[key(a, k)] = wd[8*k +: 8];
        end else if (rd) begin
            n = (sz == 3'b000 || sz == 3'b100) ? 1 : (sz == 3'b001 || sz == 3'b101) ? 2 : 4;
            v = 0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[key(a, k)]) << (8 * k));
            if (sz == 3'b000) v = 32'($signed(v[7:0]));
            if (sz == 3'b001) v = 32'($signed(v[15:0]));
            ref_rd[d] = v;
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] sz,
                          input logic [16:0] a, input logic [31:0] wd, input string tag);
        int  cyc;
        int  d;
        int  lat;
        bit  seen;
        bit  mis;
        d    = sel1 ? 1 : 0;
        lat  = sel1 ? 1 : 3;
        mis  = ref_mis(sz, a);
        ref_access(rd, wr, sz, a, wd, d);
        MemRead = rd; MemWrite = wr; SizeCtr = sz; addr = a; WriteData = wd;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (w_ready) seen = 1;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(lat));
        chk({tag, "_err"}, {31'd0, w_err}, {31'd0, mis});
        chk({tag, "_data"}, w_rdata, ref_rd[d]);
        MemRead = 0; MemWrite = 0; addr = 17'($urandom);
        @(posedge clk); #1;
        chk({tag, "_rdy_gap"}, {31'd0, w_ready}, 32'd0);
    endtask

    initial begin
        logic [2:0] sz;
        logic [2:0] st_sizes [5];
        int op;
        st_sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1; MemRead = 0; MemWrite = 0; SizeCtr = 0; addr = 0; WriteData = 0; sel1 = 0;
        ref_rd[0] = 0; ref_rd[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        chk("rst_rdata", rdata3, 32'd0);
        chk("rst_ready", {31'd0, rdy3}, 32'd0);
        chk("rst_err", {31'd0, err3}, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);

        access(0, 1, 3'b010, 17'h100, 32'hDEADBEEF, "sw100");
        access(1, 0, 3'b010, 17'h100, 32'h0, "lw100");
        chk("lw100_val", rdata3, 32'hDEADBEEF);
        access(1, 0, 3'b000, 17'h103, 32'h0, "lb103");
        chk("lb103_val", rdata3, 32'hFFFFFFDE);
        access(1, 0, 3'b100, 17'h103, 32'h0, "lbu103");
        chk("lbu103_val", rdata3, 32'h000000DE);
        access(1, 0, 3'b001, 17'h100, 32'h0, "lh100");
        chk("lh100_val", rdata3, 32'hFFFFBEEF);
        access(1, 0, 3'b101, 17'h102, 32'h0, "lhu102");
        chk("lhu102_val", rdata3, 32'h0000DEAD);
        access(0, 1, 3'b000, 17'h101, 32'h00000012, "sb101");
        access(1, 0, 3'b010, 17'h100, 32'h0, "lw100b");
        chk("sb_merge_val", rdata3, 32'hDEAD12EF);

        // Abort: request dropped in the first BUSY cycle
        access(0, 1, 3'b010, 17'h200, 32'h11223344, "sw200");
        MemWrite = 1; SizeCtr = 3'b000; addr = 17'h200; WriteData = 32'h55;
        @(posedge clk); #1;
        MemWrite = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_rdy", {31'd0, rdy3}, 32'd0);
        end
        access(1, 0, 3'b010, 17'h200, 32'h0, "lw_abort");
        chk("abort_val", rdata3, 32'h11223344);

        // Reset during BUSY cancels the pending store
        MemWrite = 1; SizeCtr = 3'b010; addr = 17'h200; WriteData = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1; MemWrite = 0;
        @(posedge clk); #1;
        rst = 0;
        ref_rd[0] = 0; ref_rd[1] = 0;
        for (int i = 0; i < 4; i++) begin
            chk("rstbusy_rdy", {31'd0, rdy3}, 32'd0);
            @(posedge clk); #1;
        end
        chk("rstbusy_rdata", rdata3, 32'd0);
        access(1, 0, 3'b010, 17'h200, 32'h0, "lw_rst");
        chk("rstbusy_val", rdata3, 32'h11223344);

        // Misaligned word store and address wrap
        access(0, 1, 3'b010, 17'h104, 32'h87654321, "sw104");
        access(0, 1, 3'b010, 17'h000, 32'h0BADF00D, "sw000");
        access(0, 1, 3'b010, 17'h1FFFC, 32'h13579BDF, "sw1fffc");
        access(0, 1, 3'b010, 17'h102, 32'hA5A5A5A5, "sw102");
        access(1, 0, 3'b010, 17'h100, 32'h0, "lw100c");
        access(1, 0, 3'b010, 17'h104, 32'h0, "lw104");
        access(0, 1, 3'b010, 17'h1FFFF, 32'h01020304, "sw_wrap");
        access(1, 0, 3'b010, 17'h1FFFC, 32'h0, "lw1fffc");
        access(1, 0, 3'b010, 17'h000, 32'h0, "lw000");

        // Randomized traffic over a preloaded window
        for (int i = 0; i < 16; i++) access(0, 1, 3'b010, 17'(32'h1000 + 4 * i), $urandom, "pre");
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0) sz = 3'($urandom_range(0, 7));
            else         sz = st_sizes[$urandom_range(0, 4)];
            access(op != 1, op != 0, sz, 17'(32'h1000 + $urandom_range(0, 60)), $urandom, "rnd");
        end

        // Single-cycle latency instance
        sel1 = 1;
        access(0, 1, 3'b010, 17'h040, 32'h89ABCDEF, "l1_sw");
        access(1, 0, 3'b010, 17'h040, 32'h0, "l1_lw");
        chk("l1_lw_val", rdata1, 32'h89ABCDEF);
        access(1, 0, 3'b000, 17'h043, 32'h0, "l1_lb");
        chk("l1_lb_val", rdata1, 32'hFFFFFF89);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Responder end of the pipeline's memory-stage request/ready interface: accepts one load or store at a time from the Memory stage, waits a programmable number of cycles, then performs the access on an internal byte-addressed array and pulses `MemReady`. It models a slow backing data memory so the pipeline's memory-stall path (`mem_stall = !MemReady && request`) is exercised under realistic latency. It sits directly below the Memory stage, in place of the single-cycle data memory.

## Interface
- `DATA_WIDTH`, 32, word width; fixed at 32.
- `ADDR_WIDTH`, 17, byte-address width; the array holds 2^ADDR_WIDTH bytes.
- `LATENCY`, 3, cycles from request acceptance to `MemReady`; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  load request; held stable by the initiator until `MemReady`.
- `MemWrite`  in  1  store request; held stable by the initiator until `MemReady`.
- `SizeCtr`  in  3  access size/sign, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  ADDR_WIDTH  byte address.
- `WriteData`  in  DATA_WIDTH  store data, right-aligned.
- `ReadData`  out  DATA_WIDTH  load result, extended to 32 bits; registered.
- `MemReady`  out  1  one-cycle completion pulse.
- `MemErr`  out  1  misaligned-access flag, valid with `MemReady`.

## Operation
- The request is `MemRead | MemWrite`. When both are high, the access is a write. In that case `ReadData` is unchanged.
- FSM states:
  - IDLE: if a request is present, latch `addr`, `SizeCtr`, `WriteData` and the operation type, load `cnt = LATENCY-1`, and go to BUSY. With LATENCY=1, go straight to RESP.
  - BUSY: decrement `cnt`. When `cnt==1`, go to RESP.
  - RESP: `MemReady=1`. A store commits its byte lanes at the edge that ends RESP. Return to IDLE unconditionally.
- Stores use the latched address and size only. Size is taken from `SizeCtr[1:0]`; 00 writes 1 byte, 01 writes 2 bytes, 10 writes 4 bytes. Byte order is little-endian at `addr`.
- Loads: `ReadData` is registered on entry to RESP.
  - B and H are sign-extended; BU and HU are zero-extended.
  - Undefined `SizeCtr` codes (011, 110, 111) read as W.
- Abort: if the request drops while in BUSY (pipeline flush), go to IDLE with no write, no `MemReady`, and `ReadData` unchanged. A change in `addr` while in BUSY is ignored, because the latched copy is used.
- Reset at any time forces IDLE and cancels any pending store. Array contents are not cleared.
- Reset values: `ReadData=0`, `MemReady=0`, `MemErr=0`, state IDLE, `cnt=0`.
- Address wrap: byte `addr+k` wraps modulo 2^ADDR_WIDTH.

## Timing
- The request is sampled in IDLE in cycle 0. `MemReady` is high in cycle LATENCY, and `ReadData` is valid in that same cycle.
- `ReadData` holds its value until the next completed load.
- After RESP there is always one IDLE cycle. The next request is sampled at cycle LATENCY+1, so back-to-back throughput is one access per LATENCY+1 cycles.
- `MemReady` is never high in two consecutive cycles.

## Configuration
- `MEM_RESP_ALIGN_CHECK_EN`
  - Defined: an H/HU access with `addr[0]=1`, or a W access with `addr[1:0]!=0`, completes with `MemReady=1` and `MemErr=1`. The store is suppressed and `ReadData` is unchanged.
  - Undefined: no check is made; misaligned accesses use the wrapping byte-wise behaviour above, and `MemErr` is tied to 0.

## Structure
- Package `mem_resp_pkg` holds:
  - the `SizeCtr` encoding localparams (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU);
  - the state enum (IDLE, BUSY, RESP).
- Sub-module `mem_resp_lane` is combinational. It produces:
  - per-byte write enables and write data from `SizeCtr` and `WriteData`;
  - load extraction and extension from the read bytes and `SizeCtr`.
- The top level holds the FSM, the counter, the latches and the byte array.

## Test plan
- Reset, then a LATENCY=3 store of W 0xDEADBEEF at 0x100 followed by a LW from 0x100 → `MemReady` in cycle 3 of each access; `ReadData=0xDEADBEEF`; the load is accepted at cycle 4 after the store.
- After the store above, LB at 0x103 → `ReadData=0xFFFFFFDE`; LBU at 0x103 → 0x000000DE; LH at 0x100 → 0xFFFFBEEF; LHU at 0x102 → 0x0000DEAD.
- SB 0x12 at 0x101, then LW at 0x100 → 0xDEAD12EF; the other bytes are intact.
- Store 0x55 at 0x200, with the request dropped in cycle 1 of BUSY → no `MemReady`; a later LW at 0x200 returns the prior contents.
- Assert `rst` during BUSY of a SW → state returns to IDLE, `MemReady` stays 0 and the memory word is unchanged. With LATENCY=1 a load completes in cycle 1.
- With `MEM_RESP_ALIGN_CHECK_EN`, SW at 0x102 → `MemReady=1`, `MemErr=1`, no write. Without the macro, the same access writes bytes 0x102..0x105 and `MemErr=0`.
